// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: operand bundle in, result bundle out,
// each with its own valid/ready pair.
interface seq_alu_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             in_c;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic [WIDTH-1:0] out_hi;
    logic             out_c;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, op, in_c, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_s, out_hi, out_c, zero, overflow
    );

    modport slave (
        input  in_valid, op, in_c, in_x, in_y, out_ready,
        output in_ready, out_valid, out_s, out_hi, out_c, zero, overflow
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic/SLT, WIDTH-cycle shift-add unsigned MUL,
// result held in a valid/ready output register.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input logic     clk,
    input logic     rst,
    seq_alu_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   out_s_reg, out_hi_reg;
    logic               out_c_reg, zero_reg, overflow_reg;
    logic [WIDTH-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] mcand_reg, prod_reg;
    logic [WIDTH-1:0]   mplier_reg;

    logic               in_ready;
    logic               accept;
    logic               res_load;
    logic [WIDTH-1:0]   res_s, res_hi;
    logic               res_c, res_ov;
    logic [WIDTH-1:0]   alu_s;
    logic               alu_c, alu_ov;
    logic [WIDTH-1:0]   y_eff;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_step;

    // A held result being consumed this cycle frees the block just as IDLE does,
    // so a new bundle can be taken in the same cycle as the result handshake.
    assign in_ready = (state_reg != MUL) && (state_reg != HOLD || bus.out_ready) && !rst;
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_s     = out_s_reg;
    assign bus.out_hi    = out_hi_reg;
    assign bus.out_c     = out_c_reg;
    assign bus.zero      = zero_reg;
    assign bus.overflow  = overflow_reg;

    // Single-cycle datapath; carry-in only reaches the adder for ADD so an
    // undriven in_c cannot leak into other results.
    always_comb begin
        y_eff  = (bus.op == OP_SUB) ? ~bus.in_y : bus.in_y;
        cin    = (bus.op == OP_ADD) ? bus.in_c : (bus.op == OP_SUB);
        sum    = {1'b0, bus.in_x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin};
        alu_s  = '0;
        alu_c  = 1'b0;
        alu_ov = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                alu_s  = sum[WIDTH-1:0];
                alu_c  = sum[WIDTH];
                alu_ov = (bus.in_x[WIDTH-1] == y_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.in_x[WIDTH-1]);
            end
            OP_NOT: alu_s = ~bus.in_x;
            OP_AND: alu_s = bus.in_x & bus.in_y;
            OP_OR:  alu_s = bus.in_x | bus.in_y;
            OP_XOR: alu_s = bus.in_x ^ bus.in_y;
            OP_SLT: alu_s = {{(WIDTH-1){1'b0}}, ($signed(bus.in_x) < $signed(bus.in_y))};
            default: alu_s = '0;
        endcase
    end

    assign prod_step = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_comb begin
        state_next = state_reg;
        res_load   = 1'b0;
        res_s      = '0;
        res_hi     = '0;
        res_c      = 1'b0;
        res_ov     = 1'b0;
        case (state_reg)
            IDLE, HOLD: begin
                if (state_reg == HOLD && bus.out_ready) begin
                    state_next = IDLE;
                end
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        state_next = MUL;
                    end else begin
                        state_next = HOLD;
                        res_load   = 1'b1;
                        res_s      = alu_s;
                        res_c      = alu_c;
                        res_ov     = alu_ov;
                    end
                end
            end
            MUL: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = HOLD;
                    res_load   = 1'b1;
                    res_s      = prod_step[WIDTH-1:0];
                    res_hi     = prod_step[2*WIDTH-1:WIDTH];
                    res_c      = |prod_step[2*WIDTH-1:WIDTH];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            out_s_reg    <= '0;
            out_hi_reg   <= '0;
            out_c_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            cnt_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            prod_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (res_load) begin
                out_s_reg    <= res_s;
                out_hi_reg   <= res_hi;
                out_c_reg    <= res_c;
                overflow_reg <= res_ov;
                zero_reg     <= (res_s == '0) && (res_hi == '0);
            end
            if (accept && bus.op == OP_MUL) begin
                mcand_reg  <= {{WIDTH{1'b0}}, bus.in_x};
                mplier_reg <= bus.in_y;
                prod_reg   <= '0;
                cnt_reg    <= '0;
            end else if (state_reg == MUL) begin
                prod_reg   <= prod_step;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=4: vector table for single-cycle ops plus
// hand sequences for MUL latency, backpressure and reset abort.
module tb_seq_alu;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seq_alu_if #(.WIDTH(4)) bus ();
    seq_alu #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic       c;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] s;
        logic       co;
        logic       z;
        logic       ov;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] s, input logic [3:0] hi,
                                input logic co, input logic z, input logic ov);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " out_s"},     32'(bus.out_s), 32'(s));
        check({tag, " out_hi"},    32'(bus.out_hi), 32'(hi));
        check({tag, " out_c"},     32'(bus.out_c), 32'(co));
        check({tag, " zero"},      32'(bus.zero), 32'(z));
        check({tag, " overflow"},  32'(bus.overflow), 32'(ov));
    endtask

    // Accept a MUL and count cycles until out_valid; returns that count.
    task automatic run_mul(input logic [3:0] x, input logic [3:0] y, output int lat);
        int busy_bad;
        busy_bad = 0;
        check("mul in_ready before", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.op = 3'b111; bus.in_c = 1'b0; bus.in_x = x; bus.in_y = y;
        tick();
        bus.in_valid = 1'b0; bus.in_x = ~x; bus.in_y = ~y;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) busy_bad++;
            tick();
            lat++;
        end
        check("mul in_ready low while busy", 32'(busy_bad), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{3'b000, 1'b0, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{3'b000, 1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'b000, 1'b1, 4'h5, 4'h3, 4'h9, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{3'b001, 1'b0, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b001, 1'b0, 4'h8, 4'h1, 4'h7, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{3'b001, 1'b0, 4'h5, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{3'b001, 1'b1, 4'h4, 4'h1, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 1'b1, 4'h5, 4'h3, 4'hA, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b011, 1'b1, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b100, 1'b0, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'b101, 1'b0, 4'hC, 4'hC, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{3'b110, 1'b0, 4'h8, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b110, 1'b0, 4'h1, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{3'b110, 1'b1, 4'h3, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b000, 1'b1, 4'h2, 4'h3, 4'h6, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = 3'b000; bus.in_c = 1'b0;
        bus.in_x = 4'h0; bus.in_y = 4'h0; bus.out_ready = 1'b1;
        tick();
        tick();
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_s", 32'(bus.out_s), 32'd0);
        check("reset out_hi", 32'(bus.out_hi), 32'd0);
        check("reset flags", 32'({bus.out_c, bus.zero, bus.overflow}), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after release", 32'(bus.in_ready), 32'd1);
        $display("reset sequence done");

        for (int i = 0; i < 16; i++) begin
            check("vec in_ready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b1; bus.op = vecs[i].op; bus.in_c = vecs[i].c;
            bus.in_x = vecs[i].x; bus.in_y = vecs[i].y;
            tick();
            bus.in_valid = 1'b0; bus.in_x = 4'h0; bus.in_y = 4'h0;
            check_result($sformatf("vec%0d", i), vecs[i].s, 4'h0, vecs[i].co, vecs[i].z, vecs[i].ov);
            $display("vec %0d op=%0d x=%0h y=%0h c=%0b -> s=%0h c=%0b z=%0b ov=%0b", i,
                     vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].c, bus.out_s, bus.out_c,
                     bus.zero, bus.overflow);
            tick();
            check("vec drained", 32'(bus.out_valid), 32'd0);
        end

        run_mul(4'hF, 4'hF, lat);
        check("mul FxF latency", 32'(lat), 32'd5);
        check_result("mul FxF", 4'h1, 4'hE, 1'b1, 1'b0, 1'b0);
        $display("mul F*F latency=%0d s=%0h hi=%0h", lat, bus.out_s, bus.out_hi);
        tick();
        run_mul(4'h3, 4'h5, lat);
        check("mul 3x5 latency", 32'(lat), 32'd5);
        check_result("mul 3x5", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        $display("mul 3*5 latency=%0d s=%0h hi=%0h", lat, bus.out_s, bus.out_hi);
        tick();
        run_mul(4'h0, 4'h7, lat);
        check_result("mul 0x7", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        $display("mul 0*7 latency=%0d zero=%0b", lat, bus.zero);
        tick();
        bus.in_valid = 1'b1; bus.op = 3'b000; bus.in_c = 1'b0; bus.in_x = 4'h2; bus.in_y = 4'h3;
        tick();
        bus.in_valid = 1'b0;
        check_result("add after mul", 4'h5, 4'h0, 1'b0, 1'b0, 1'b0);
        $display("add after mul s=%0h hi=%0h", bus.out_s, bus.out_hi);
        tick();

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = 3'b000; bus.in_c = 1'b0; bus.in_x = 4'h1; bus.in_y = 4'h1;
        tick();
        bus.in_valid = 1'b0; bus.in_x = 4'h9;
        for (int k = 0; k < 3; k++) begin
            check_result($sformatf("stall%0d", k), 4'h2, 4'h0, 1'b0, 1'b0, 1'b0);
            check($sformatf("stall%0d in_ready", k), 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = 3'b011; bus.in_x = 4'hC; bus.in_y = 4'hA;
        #1;
        check("overlap in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_result("overlap and", 4'h8, 4'h0, 1'b0, 1'b0, 1'b0);
        $display("backpressure then overlap: s=%0h", bus.out_s);
        tick();
        check("overlap drained", 32'(bus.out_valid), 32'd0);

        bus.in_valid = 1'b1; bus.op = 3'b111; bus.in_x = 4'hF; bus.in_y = 4'hF;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort in_ready in rst", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("abort no result", 32'(seen), 32'd0);
        $display("mul abort by reset: results seen=%0d", seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
